// File: rtl/clk_pkg.sv
// Shared constants, run-control states and increment helper for the clk25 enable generators.
package clk_pkg;

  localparam longint unsigned CLK_HZ = 25_000_000;
  localparam int              ACC_W  = 24;

  typedef enum logic [1:0] {
    RUN,
    HALT,
    STEP_WAIT
  } run_state_t;

  // round(2^ACC_W * hz / CLK_HZ); hz * 2^24 stays well inside 64 bits for any sub-clk25 rate
  function automatic logic [ACC_W-1:0] phase_inc(input longint unsigned hz);
    longint unsigned num;
    num = (hz << ACC_W) + (CLK_HZ / 2);
    return ACC_W'(num / CLK_HZ);
  endfunction

endpackage

// File: rtl/phase_acc.sv
// Free-running phase accumulator; carry is the registered carry-out of each add.
module phase_acc #(
  parameter int          ACC_W = 24,
  parameter int unsigned INC   = 1
) (
  input  logic clk25,
  input  logic rst,
  output logic carry
);

  logic [ACC_W-1:0] acc_p0;
  logic [ACC_W:0]   sum;
  logic             carry_p1;

  assign sum = {1'b0, acc_p0} + (ACC_W+1)'(INC);

  // accumulate stage: wrap is intentional, carry-out becomes the enable one cycle later
  always_ff @(posedge clk25) begin
    if (rst) begin
      acc_p0   <= '0;
      carry_p1 <= 1'b0;
    end else begin
      acc_p0   <= sum[ACC_W-1:0];
      carry_p1 <= sum[ACC_W];
    end
  end

  assign carry = carry_p1;

endmodule

// File: rtl/clock_enables.sv
// Master clock-enable generator for the clk25 domain: CPU and UART phase accumulators,
// 1 kHz power-up tick, and CPU run/halt/single-step control.
module clock_enables
  import clk_pkg::*;
#(
  parameter int          ACC_W    = 24,
  parameter int unsigned CPU_INC  = 32'(phase_inc(1_000_000)),
  parameter int unsigned UART_INC = 32'(phase_inc(1_843_200)),
  parameter int          PWR_DIV  = 25000
) (
  input  logic clk25,
  input  logic rst,
  input  logic halt_req,
  input  logic run_req,
  input  logic step_req,
  output logic cpu_clken,
  output logic uart_clken,
  output logic pwr_tick,
  output logic step_ack,
  output logic halted
);

  localparam int               PWR_W    = $clog2(PWR_DIV);
  localparam logic [PWR_W-1:0] PWR_LAST = PWR_W'(PWR_DIV - 1);

  logic             cpu_carry;
  logic             uart_carry;
  logic [PWR_W-1:0] pwr_cnt;
  logic             pwr_tick_p1;
  run_state_t       state;
  run_state_t       state_nxt;
  logic             cpu_en;
  logic             ack_en;

  phase_acc #(.ACC_W(ACC_W), .INC(CPU_INC)) u_cpu_acc (
    .clk25 (clk25),
    .rst   (rst),
    .carry (cpu_carry)
  );

  phase_acc #(.ACC_W(ACC_W), .INC(UART_INC)) u_uart_acc (
    .clk25 (clk25),
    .rst   (rst),
    .carry (uart_carry)
  );

  // power tick stage: pulse registered on the cycle the counter wraps back to 0
  always_ff @(posedge clk25) begin
    if (rst) begin
      pwr_cnt     <= '0;
      pwr_tick_p1 <= 1'b0;
    end else if (pwr_cnt == PWR_LAST) begin
      pwr_cnt     <= '0;
      pwr_tick_p1 <= 1'b1;
    end else begin
      pwr_cnt     <= pwr_cnt + PWR_W'(1);
      pwr_tick_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk25) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  // halt wins over run, run over step; a pending step is released by the next CPU carry
  always_comb begin
    state_nxt = state;
    cpu_en    = 1'b0;
    ack_en    = 1'b0;
    case (state)
      RUN: begin
        if (halt_req) state_nxt = HALT;
        else          cpu_en    = cpu_carry;
      end
      HALT: begin
        if (halt_req)      state_nxt = HALT;
        else if (run_req)  state_nxt = RUN;
        else if (step_req) state_nxt = STEP_WAIT;
      end
      STEP_WAIT: begin
        if (run_req) begin
          state_nxt = RUN;
          cpu_en    = cpu_carry;
        end else if (cpu_carry) begin
          state_nxt = HALT;
          cpu_en    = 1'b1;
          ack_en    = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // outputs are forced low while reset is asserted, including the cycle it is sampled
  assign cpu_clken  = cpu_en & ~rst;
  assign step_ack   = ack_en & ~rst;
  assign uart_clken = uart_carry & ~rst;
  assign pwr_tick   = pwr_tick_p1 & ~rst;
  assign halted     = (state != RUN) & ~rst;

endmodule

// File: tb/tb_clock_enables.sv
// Directed bench for clock_enables: enable cadences, power tick, halt/step/run control, reset.
module tb_clock_enables;

  logic clk25 = 1'b0;
  logic rst = 1'b1;
  logic halt_req = 1'b0;
  logic run_req = 1'b0;
  logic step_req = 1'b0;
  logic cpu_clken, uart_clken, pwr_tick, step_ack, halted;

  clock_enables dut (
    .clk25      (clk25),
    .rst        (rst),
    .halt_req   (halt_req),
    .run_req    (run_req),
    .step_req   (step_req),
    .cpu_clken  (cpu_clken),
    .uart_clken (uart_clken),
    .pwr_tick   (pwr_tick),
    .step_ack   (step_ack),
    .halted     (halted)
  );

  always #20 clk25 = ~clk25;

  int n_checks = 0;
  int n_fail = 0;
  int cycle = 0;
  int cpu_cnt, first_cpu, last_cpu, bad_gap, cpu_wide;
  int uart_cnt, uart_wide;
  int pwr_cnt, pwr_first, pwr_second, pwr_wide;
  int ack_cnt, ack_mis;
  logic cpu_prev, uart_prev, pwr_prev;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cycle);
    end
  endtask

  task automatic clear_stats();
    cpu_cnt = 0; first_cpu = 0; last_cpu = 0; bad_gap = 0; cpu_wide = 0;
    uart_cnt = 0; uart_wide = 0;
    pwr_cnt = 0; pwr_first = 0; pwr_second = 0; pwr_wide = 0;
    ack_cnt = 0; ack_mis = 0;
    cpu_prev = 1'b0; uart_prev = 1'b0; pwr_prev = 1'b0;
  endtask

  // one clk25 cycle; outputs sampled on the falling edge, inputs changed by callers afterwards
  task automatic tick();
    @(posedge clk25);
    cycle++;
    @(negedge clk25);
    if (cpu_clken) begin
      if (cpu_prev) cpu_wide++;
      if (last_cpu != 0 && cycle - last_cpu != 25) bad_gap++;
      if (first_cpu == 0) first_cpu = cycle;
      last_cpu = cycle;
      cpu_cnt++;
    end
    if (uart_clken) begin
      if (uart_prev) uart_wide++;
      uart_cnt++;
    end
    if (pwr_tick) begin
      if (pwr_prev) pwr_wide++;
      if (pwr_cnt == 0) pwr_first = cycle;
      else if (pwr_cnt == 1) pwr_second = cycle;
      pwr_cnt++;
    end
    if (step_ack) begin
      ack_cnt++;
      if (!cpu_clken) ack_mis++;
    end
    cpu_prev = cpu_clken;
    uart_prev = uart_clken;
    pwr_prev = pwr_tick;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val(tag, 32'({cpu_clken, uart_clken, pwr_tick, step_ack, halted}), 32'd0);
    end
    rst = 1'b0;
    cycle = 0;
    clear_stats();
  endtask

  initial begin
    clear_stats();

    // free-running cadence and power tick
    do_reset("reset_outputs");
    ticks(25000);
    check_val("cpu_first", first_cpu, 25);
    check_val("cpu_count_25k", cpu_cnt, 1000);
    check_val("cpu_gap", bad_gap, 0);
    check_val("cpu_width", cpu_wide, 0);
    check_val("halted_run", halted, 0);
    check_val("uart_count_25k", uart_cnt, 1843);
    check_val("pwr_first", pwr_first, 25000);
    check_val("pwr_count_25k", pwr_cnt, 1);
    ticks(25000);
    check_val("pwr_second", pwr_second, 50000);
    check_val("pwr_width", pwr_wide, 0);
    check_val("cpu_count_50k", cpu_cnt, 2000);
    check_val("uart_count_50k", uart_cnt, 3686);
    check_val("uart_width", uart_wide, 0);

    // halt at cycle 100 suppresses the carry there and everything after
    do_reset("reset_outputs_b");
    ticks(99);
    check_val("cpu_pre_halt", cpu_cnt, 3);
    halt_req = 1'b1;
    tick();
    check_val("halt_suppress", cpu_clken, 0);
    check_val("halted_set", halted, 1);
    halt_req = 1'b0;
    clear_stats();
    ticks(100);
    check_val("halt_no_cpu", cpu_cnt, 0);

    // single step lands on the next carry (cycle 225) with a coincident ack
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    ticks(39);
    check_val("step_cpu_count", cpu_cnt, 1);
    check_val("step_cpu_cycle", last_cpu, 225);
    check_val("step_ack_count", ack_cnt, 1);
    check_val("step_ack_align", ack_mis, 0);
    check_val("step_halted", halted, 1);
    ticks(60);
    check_val("step_one_only", cpu_cnt, 1);

    // resume
    run_req = 1'b1;
    tick();
    run_req = 1'b0;
    clear_stats();
    ticks(99);
    check_val("run_cpu_count", cpu_cnt, 4);
    check_val("run_cpu_first", first_cpu, 325);
    check_val("run_gap", bad_gap, 0);
    check_val("run_halted", halted, 0);

    // halt and run together in RUN: halt wins
    halt_req = 1'b1;
    run_req = 1'b1;
    tick();
    halt_req = 1'b0;
    run_req = 1'b0;
    check_val("halt_over_run", halted, 1);
    clear_stats();
    ticks(49);
    check_val("halt_over_run_cpu", cpu_cnt, 0);
    run_req = 1'b1;
    tick();
    run_req = 1'b0;

    // step in RUN is ignored
    clear_stats();
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    ticks(73);
    check_val("run_step_cpu", cpu_cnt, 3);
    check_val("run_step_first", first_cpu, 475);
    check_val("run_step_ack", ack_cnt, 0);
    check_val("run_step_gap", bad_gap, 0);

    // reset while a step is pending
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    ticks(13);
    check_val("stepwait_halted", halted, 1);
    check_val("stepwait_no_cpu", cpu_clken, 0);
    clear_stats();
    rst = 1'b1;
    tick();
    check_val("rst_mid_step", 32'({cpu_clken, uart_clken, pwr_tick, step_ack, halted}), 32'd0);
    do_reset("rst_mid_step_hold");
    ticks(60);
    check_val("post_rst_ack", ack_cnt, 0);
    check_val("post_rst_cpu_first", first_cpu, 25);
    check_val("post_rst_cpu_count", cpu_cnt, 2);
    check_val("post_rst_halted", halted, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
